dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory (1-cycle registered read, write on clock edge) between two requesters: m0, the pipeline MEM stage, and m1, the program loader/debug port.
- One access per cycle. m0 has priority, bounded by an m1 starvation limit and an m1 burst lock.
- Sits between the requesters and the memory array. The GPIO decode stays outside it.

Parameters:
- ADDR_SIZE, 10, word address width
- WORD_SIZE, 32, data width
- STARVE_LIMIT, 8, number of consecutive m1 waiting cycles before m1 is forced a grant (>=1)
- MAX_BURST, 4, maximum back-to-back m1 grants under lock while m0 is waiting (>=1)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous reset, active-high
- m0_req  in  1  m0 access request
- m0_we  in  1  m0 write enable (1 = write, 0 = read)
- m0_addr  in  ADDR_SIZE  m0 word address
- m0_wdata  in  WORD_SIZE  m0 write data
- m0_gnt  out  1  m0 access accepted this cycle (combinational)
- m0_rvalid  out  1  m0 read data valid on rdata
- m1_req, m1_we, m1_addr, m1_wdata  in  as for m0  m1 request fields
- m1_lock  in  1  m1 asks to keep ownership for its next access
- m1_gnt  out  1  m1 access accepted this cycle (combinational)
- m1_rvalid  out  1  m1 read data valid on rdata
- rdata  out  WORD_SIZE  read data, passed through from mem_rdata
- mem_addr  out  ADDR_SIZE  memory address
- mem_we  out  1  memory write strobe
- mem_wdata  out  WORD_SIZE  memory write data
- mem_rdata  in  WORD_SIZE  memory read data, valid one cycle after the address

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: m0_rvalid=0, m1_rvalid=0, starve_cnt=0, burst_cnt=0, last_m1=0. m0_gnt/m1_gnt are combinational and are 0 while rst=1. mem_we is 0 while rst=1.
- Grant rule, evaluated each cycle:
  - force_m1 = m1_req && (starve_cnt==STARVE_LIMIT || (last_m1 && m1_lock && burst_cnt<MAX_BURST)).
  - m1_gnt = m1_req && (!m0_req || force_m1).
  - m0_gnt = m0_req && !m1_gnt.
- At most one grant per cycle. No grant means mem_we=0; mem_addr holds its last value (don't-care).
- Memory mux: the granted master's addr/wdata drive mem_addr/mem_wdata. mem_we = gnt && that master's we.
- Read latency is 1 cycle:
  - On a granted read, the granting master's rvalid is 1 in the next cycle; the other rvalid is 0.
  - rdata = mem_rdata, combinational passthrough.
  - A granted write produces no rvalid.
- starve_cnt:
  - Cleared when m1_gnt=1 or when m1_req=0.
  - Otherwise (m1 waiting) increments, saturating at STARVE_LIMIT.
- last_m1 <= m1_gnt each cycle.
- burst_cnt:
  - On m1_gnt with m0_req=1: burst_cnt+1, saturating.
  - On m1_gnt with m0_req=0: cleared.
  - On m0_gnt: cleared.
  - With no grant: holds.
- Lock semantics:
  - The lock only extends an ownership m1 already holds (last_m1=1).
  - Once MAX_BURST locked grants have been made while m0 was waiting, m0 receives the next grant, which resets burst_cnt.
- m0 is never blocked for more than MAX_BURST consecutive cycles. m1 waits at most STARVE_LIMIT cycles.
- Requesters hold req/addr/we/wdata stable until their gnt is seen. The arbiter has no request buffering.
- Reset during an outstanding read: the pending rvalid is dropped (forced to 0 next cycle).

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- When defined:
  - Adds output conflict_cnt (32 bits): increments on every cycle with m0_req && m1_req, saturating at all-ones.
  - Adds output force_cnt (16 bits): increments on every m1 grant caused by starve_cnt==STARVE_LIMIT, saturating.
  - Both counters clear on rst.
- When not defined: these ports and registers do not exist. Arbitration behaviour is identical either way.

Decomposition:
- Shared package mips_mem_pkg: ADDR_SIZE/WORD_SIZE defaults and master-index constants (M0=0, M1=1).
- One natural sub-module, dmem_arb_fair: holds starve_cnt, burst_cnt, last_m1 and computes force_m1.
- Mux and rvalid pipeline stay in the top level.

Test Plan:
- Read latency: after reset, m0 writes 0xDEADBEEF to addr 5, then reads addr 5 → m0_gnt=1 on both cycles; m0_rvalid=1 exactly 1 cycle after the read grant with rdata=0xDEADBEEF; m1_rvalid stays 0.
- Contention: m0_req and m1_req held high continuously, m1_lock=0, STARVE_LIMIT=8 → m0 granted 8 cycles, m1 granted on the 9th; pattern repeats with period 9.
- Burst lock: m1 holds ownership with m1_lock=1, m0_req rises and stays high, MAX_BURST=4 → m1 granted 4 more cycles, then m0 granted; burst_cnt back to 0.
- Write interleave: m0 writes 0x11 and m1 writes 0x22 to addr 7 in the same cycle with starve_cnt=0 → only m0 is granted; m1 is granted next cycle; a final read of addr 7 returns 0x22.
- Mid-read reset: m1 read granted, rst=1 in the following cycle → m1_rvalid=0, mem_we=0, all counters 0 one cycle later.
- Stats (DMEM_ARB_STATS_EN defined): 20 cycles of dual requests → conflict_cnt=20, force_cnt=2.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// ============================================================================
// mips_mem_pkg : shared data-memory widths and master indices
// Rev 1.0
// ============================================================================
`default_nettype none

package mips_mem_pkg;

   localparam int unsigned c_ADDR_SIZE = 10;
   localparam int unsigned c_WORD_SIZE = 32;

   typedef enum logic {
      M0 = 1'b0,
      M1 = 1'b1
   } master_e;

endpackage

`default_nettype wire

// File: rtl/dmem_arb_fair.sv
// ============================================================================
// dmem_arb_fair : m1 starvation and burst-lock tracking, produces force_m1
// Rev 1.0
// ============================================================================
`default_nettype none

module dmem_arb_fair
   import mips_mem_pkg::*;
#(
   parameter int STARVE_LIMIT = 8,
   parameter int MAX_BURST    = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_m0_req,
   input  logic i_m1_req,
   input  logic i_m1_lock,
   input  logic i_m0_gnt,
   input  logic i_m1_gnt,
   output logic o_force_m1,
   output logic o_starved
);

   localparam int c_SW = $clog2(STARVE_LIMIT + 1);
   localparam int c_BW = $clog2(MAX_BURST + 1);

   logic [c_SW-1:0] r_starve_cnt;
   logic [c_BW-1:0] r_burst_cnt;
   logic            r_last_m1;
   logic            w_starved;
   logic            w_burst_ok;

   assign w_starved  = (r_starve_cnt == c_SW'(STARVE_LIMIT));
   assign w_burst_ok = (r_burst_cnt < c_BW'(MAX_BURST));
   // The lock may only extend ownership m1 held in the previous cycle.
   assign o_force_m1 = i_m1_req && (w_starved || (r_last_m1 && i_m1_lock && w_burst_ok));
   assign o_starved  = w_starved;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_starve_cnt <= '0;
         r_burst_cnt  <= '0;
         r_last_m1    <= 1'b0;
      end else begin
         if (i_m1_gnt || !i_m1_req)
            r_starve_cnt <= '0;
         else if (!w_starved)
            r_starve_cnt <= r_starve_cnt + c_SW'(1);

         r_last_m1 <= i_m1_gnt;

         if (i_m1_gnt) begin
            if (!i_m0_req)
               r_burst_cnt <= '0;
            else if (w_burst_ok)
               r_burst_cnt <= r_burst_cnt + c_BW'(1);
         end else if (i_m0_gnt) begin
            r_burst_cnt <= '0;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter : two-master arbiter for the single-port data memory
// Optional statistics counters with DMEM_ARB_STATS_EN.      Rev 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter
   import mips_mem_pkg::*;
#(
   parameter int ADDR_SIZE    = c_ADDR_SIZE,
   parameter int WORD_SIZE    = c_WORD_SIZE,
   parameter int STARVE_LIMIT = 8,
   parameter int MAX_BURST    = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 m0_req,
   input  logic                 m0_we,
   input  logic [ADDR_SIZE-1:0] m0_addr,
   input  logic [WORD_SIZE-1:0] m0_wdata,
   output logic                 m0_gnt,
   output logic                 m0_rvalid,
   input  logic                 m1_req,
   input  logic                 m1_we,
   input  logic [ADDR_SIZE-1:0] m1_addr,
   input  logic [WORD_SIZE-1:0] m1_wdata,
   input  logic                 m1_lock,
   output logic                 m1_gnt,
   output logic                 m1_rvalid,
   output logic [WORD_SIZE-1:0] rdata,
   output logic [ADDR_SIZE-1:0] mem_addr,
   output logic                 mem_we,
   output logic [WORD_SIZE-1:0] mem_wdata,
`ifdef DMEM_ARB_STATS_EN
   output logic [31:0]          conflict_cnt,
   output logic [15:0]          force_cnt,
`endif
   input  logic [WORD_SIZE-1:0] mem_rdata
);

   logic    w_force_m1;
   master_e w_sel;
   logic    r_m0_rvalid;
   logic    r_m1_rvalid;
`ifdef DMEM_ARB_STATS_EN
   logic        w_starved;
   logic [31:0] r_conflict_cnt;
   logic [15:0] r_force_cnt;
`endif

   dmem_arb_fair #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .MAX_BURST    (MAX_BURST)
   ) u_fair (
      .clk        (clk),
      .rst        (rst),
      .i_m0_req   (m0_req),
      .i_m1_req   (m1_req),
      .i_m1_lock  (m1_lock),
      .i_m0_gnt   (m0_gnt),
      .i_m1_gnt   (m1_gnt),
      .o_force_m1 (w_force_m1),
`ifdef DMEM_ARB_STATS_EN
      .o_starved  (w_starved)
`else
      .o_starved  ()
`endif
   );

   assign m1_gnt = !rst && m1_req && (!m0_req || w_force_m1);
   assign m0_gnt = !rst && m0_req && !m1_gnt;

   // Address/data follow m0 when idle; only mem_we qualifies an access.
   assign w_sel     = m1_gnt ? M1 : M0;
   assign mem_addr  = (w_sel == M1) ? m1_addr  : m0_addr;
   assign mem_wdata = (w_sel == M1) ? m1_wdata : m0_wdata;
   assign mem_we    = (m0_gnt && m0_we) || (m1_gnt && m1_we);
   assign rdata     = mem_rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_m0_rvalid <= 1'b0;
         r_m1_rvalid <= 1'b0;
      end else begin
         r_m0_rvalid <= m0_gnt && !m0_we;
         r_m1_rvalid <= m1_gnt && !m1_we;
      end
   end

   assign m0_rvalid = r_m0_rvalid;
   assign m1_rvalid = r_m1_rvalid;

`ifdef DMEM_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         r_conflict_cnt <= '0;
         r_force_cnt    <= '0;
      end else begin
         if (m0_req && m1_req && (r_conflict_cnt != '1))
            r_conflict_cnt <= r_conflict_cnt + 32'd1;
         if (m1_gnt && w_starved && (r_force_cnt != '1))
            r_force_cnt <= r_force_cnt + 16'd1;
      end
   end

   assign conflict_cnt = r_conflict_cnt;
   assign force_cnt    = r_force_cnt;
`endif

endmodule

`default_nettype wire
